// File: rtl/car_sensor_if.sv
// Request channel between the east/west loop-detector conditioner and the light controller.
// The slave modport is the conditioner; the master modport is the controller/detector side.
interface car_sensor_if #(
    parameter int WW = 8
);
    logic          loop;
    logic          served;
    logic          carew;
    logic [WW-1:0] wait_cyc;

    modport master (
        output loop,
        output served,
        input  carew,
        input  wait_cyc
    );

    modport slave (
        input  loop,
        input  served,
        output carew,
        output wait_cyc
    );
endinterface

// File: rtl/car_sensor.sv
// East/west vehicle-presence conditioner: debounces the loop detector, holds a request until served.
// Build option CAR_SENSOR_SYNC_EN inserts a two-flop synchroniser on the raw loop input.
module car_sensor #(
    parameter int DB_CYCLES = 4,
    parameter int WW        = 8
) (
    input  logic        clk,
    input  logic        rst,
    car_sensor_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        QUAL   = 4'b0010,
        REQ    = 4'b0100,
        SERVED = 4'b1000
    } state_e;

    localparam logic [7:0]    QUAL_LAST = 8'(DB_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = '1;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          carew_q, carew_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          s;

`ifdef CAR_SENSOR_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = bus.loop;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    // Caller guarantees loop is already synchronous to clk in this build.
    assign s = bus.loop;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = 8'd0;
        wait_d  = '0;

        case (state_q)
            IDLE: begin
                if (s && !bus.served) begin
                    state_d = QUAL;
                    cnt_d   = 8'd1;
                end
            end
            QUAL: begin
                // A car already being served never needs a new request.
                if (bus.served || !s) begin
                    state_d = IDLE;
                end else if (cnt_q == QUAL_LAST) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REQ: begin
                if (bus.served) begin
                    state_d = SERVED;
                end else begin
                    wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
                end
            end
            SERVED: begin
                if (!bus.served) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // Corrupted or non-one-hot encoding falls back to a quiet IDLE.
                state_d = IDLE;
            end
        endcase

        carew_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            carew_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carew_q <= carew_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.carew    = carew_q;
    assign bus.wait_cyc = wait_q;

endmodule

// File: tb/tb_car_sensor.sv
// Directed self-checking bench for car_sensor: vector table plus saturation and reset corner sequences.
// Expected values assume DB_CYCLES=4; CAR_SENSOR_SYNC_EN selects the synchronised-latency sequence.
module tb_car_sensor;

    typedef struct {
        logic       rst;
        logic       loop;
        logic       served;
        logic       exp_carew;
        logic [7:0] exp_wait;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks_total  = 0;
    int checks_passed = 0;

    car_sensor_if #(.WW(8)) bus8 ();
    car_sensor_if #(.WW(2)) bus2 ();

    car_sensor #(.DB_CYCLES(4), .WW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    car_sensor #(.DB_CYCLES(4), .WW(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
    task automatic step(input logic r, input logic l, input logic s);
        rst         = r;
        bus8.loop   = l;
        bus8.served = s;
        bus2.loop   = l;
        bus2.served = s;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic s,
                       input logic c, input logic [7:0] w);
        vec_t v;
        v.rst = r; v.loop = l; v.served = s; v.exp_carew = c; v.exp_wait = w;
        vecs.push_back(v);
    endtask

    initial begin
        bus8.loop = 1'b1; bus8.served = 1'b1;
        bus2.loop = 1'b1; bus2.served = 1'b1;

`ifdef CAR_SENSOR_SYNC_EN
        // Reset, then loop rises before edge 1: request first appears after edge 6.
        step(1, 1, 1);
        check("sync_reset_carew", bus8.carew, 0);
        step(1, 1, 1);
        check("sync_reset_wait", bus8.wait_cyc, 0);
        for (int e = 1; e <= 6; e++) begin
            step(0, 1, 0);
            check($sformatf("sync_qual_edge%0d", e), bus8.carew, (e == 6) ? 1 : 0);
        end
        step(0, 1, 0);
        check("sync_wait_1", bus8.wait_cyc, 1);
        step(0, 0, 1);
        check("sync_clear", bus8.carew, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(1, 1, 0);
        check("sync_reset_midqual", bus8.carew, 0);
        for (int e = 1; e <= 6; e++) begin
            step(0, 1, 0);
            check($sformatf("sync_requal_edge%0d", e), bus8.carew, (e == 6) ? 1 : 0);
        end
`else
        // Reset with loop and served high.
        add(1, 1, 1, 0, 0);
        add(1, 1, 1, 0, 0);
        // Qualification: request after the 4th high edge, then wait counts 0,1,2.
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 1, 2);
        // Request held with loop gone.
        add(0, 0, 0, 1, 3);
        add(0, 0, 0, 1, 4);
        // Serve clears in one edge; no request while green with loop high.
        add(0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0);
        // Green drops: IDLE, then QUAL, request on the 4th edge after rearm.
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0);
        // Serve and release to IDLE.
        add(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        // Glitch: high 3, low 1, then continuous high.
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0);
        // Served during QUAL aborts qualification.
        add(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1);
        // Reset mid-REQ dominates loop.
        add(1, 1, 0, 0, 0);
        // Reset mid-QUAL restarts the debounce count.
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].loop, vecs[i].served);
            check($sformatf("vec%0d_carew", i), bus8.carew, vecs[i].exp_carew);
            check($sformatf("vec%0d_wait", i), bus8.wait_cyc, vecs[i].exp_wait);
        end

        // Saturation with WW=2: wait counts 0,1,2,3,3,3 while held in REQ.
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        for (int e = 0; e < 6; e++) begin
            step(0, 1, 0);
            check($sformatf("sat_carew%0d", e), bus2.carew, 1);
            check($sformatf("sat_wait%0d", e), bus2.wait_cyc, (e > 3) ? 3 : e);
        end
        check("nosat_wait", bus8.wait_cyc, 5);
        step(1, 1, 0);
        check("sat_reset_carew", bus2.carew, 0);
        check("sat_reset_wait", bus2.wait_cyc, 0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/car_sensor.md
# car_sensor

Vehicle-presence conditioner for the east/west approach, directly upstream of the intersection light controller. It synchronises and debounces the raw inductive-loop detector and latches a qualified request. It drives that request on `carew`, and clears it once the controller shows east/west green (`served`, tied to the controller's `gew` light bit). It also reports how long the current request has been waiting, for diagnostics.

## Interface
- `DB_CYCLES`, 4: consecutive clock edges `loop` must be seen high to qualify a car; legal range 2..255.
- `WW`, 8: width of `wait_cyc`.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `loop`  in  1  raw loop detector, asynchronous, may glitch.
- `served`  in  1  high while east/west green is displayed (controller `lights[2]`).
- `carew`  out  1  registered request to the light controller; 1 = car waiting east/west.
- `wait_cyc`  out  WW  registered count of cycles spent in REQ, saturating.

## Operation
- Internal signal `s` is the sampled `loop`: either synchronised or direct, per Configuration.
- Counter `cnt` is 8 bits wide.
- State machine has four states, one-hot: IDLE, QUAL, REQ, SERVED.
- IDLE:
  - `s`=1 and `served`=0 -> QUAL, `cnt`=1.
  - Otherwise stay in IDLE, `cnt`=0.
- QUAL:
  - `served`=1 -> IDLE, `cnt`=0. The car is already being served.
  - Else `s`=0 -> IDLE, `cnt`=0. A glitch is rejected.
  - Else `cnt`==DB_CYCLES-1 -> REQ, `carew`=1, `wait_cyc`=0.
  - Else stay in QUAL, `cnt`+1.
- REQ:
  - `carew` is held at 1 regardless of `loop`; a qualified car stays requested even if it leaves.
  - `served`=1 -> SERVED, `carew`=0, `wait_cyc`=0.
  - Otherwise stay in REQ; `wait_cyc` increments, saturating at 2^WW-1 with no wrap.
- SERVED:
  - `served`=0 -> IDLE.
  - Otherwise stay in SERVED. No new request can form while green is shown.
- `carew`=1 if and only if the state is REQ.
- `wait_cyc`=0 outside REQ.
- Reset:
  - `rst`=1 at an edge forces IDLE, `cnt`=0, `carew`=0, `wait_cyc`=0, and synchroniser flops to 0.
  - Reset applies from any state, including mid-QUAL and mid-REQ.
  - It overrides `loop` and `served` on the same edge.
- An illegal or non-one-hot state recovers to IDLE on the next edge, with outputs 0.

## Timing
- Reset values: `carew`=0, `wait_cyc`=0.
- Qualification latency, without synchroniser:
  - `loop` goes high before edge k and is held.
  - `carew` is 1 after edge k+DB_CYCLES-1, i.e. DB_CYCLES edges inclusive.
- With synchroniser: the same, plus 2 edges.
- Clear latency: `served` high before edge n in REQ -> `carew`=0 after edge n (one edge).
- Rearm: `served` low before edge m in SERVED -> IDLE after edge m. A new QUAL can start at edge m+1 at the earliest.
- Simultaneous events:
  - `served`=1 dominates `s` in IDLE and QUAL.
  - `rst` dominates everything.
- The light controller samples `carew` only in its north/south green state. Holding the request until `served` guarantees it is never lost.

## Configuration
- `CAR_SENSOR_SYNC_EN` defined:
  - `loop` passes through a two-flop synchroniser (reset to 0) before `s`.
  - Adds 2 cycles to qualification latency.
- `CAR_SENSOR_SYNC_EN` undefined:
  - `s` = `loop` directly. Use only when `loop` is already synchronous to `clk`.
- State machine behaviour is otherwise identical in both builds.

## Test plan
All scenarios use DB_CYCLES=4, WW=8, synchroniser off, unless stated otherwise.
- Reset clears state: `rst`=1 for 2 edges with `loop`=1 and `served`=1 -> `carew`=0 and `wait_cyc`=0 throughout and after.
- Qualification: `loop` rises before edge 1 and is held -> `carew`=0 after edges 1–3 and 1 after edge 4. `wait_cyc` reads 0, 1, 2 after edges 4, 5, 6.
- Glitch rejection: `loop` high for 3 edges, low 1, high 3 -> `carew` never asserts. Then hold `loop` high -> `carew`=1 on the 4th consecutive high edge.
- Serve handshake: in REQ, `served`=1 at edge 10 -> `carew`=0 and `wait_cyc`=0 after edge 10. Hold `served` high with `loop` high for 10 edges -> no request. Drop `served` at edge 20, `loop` high -> `carew`=1 after edge 24.
- Saturation and reset: WW=2, hold REQ for 6 edges -> `wait_cyc` reads 0, 1, 2, 3, 3, 3. `rst`=1 mid-REQ -> `carew`=0 next edge.
- `CAR_SENSOR_SYNC_EN` defined: `loop` rises before edge 1 and is held -> `carew`=1 first after edge 6.
